iq_demod_integrate_dump: RTL and testbench

- Receive-side stage directly downstream of the I/Q modulator.
- Takes the modulated sample stream together with the matching NCO cosine/sine carriers.
- Mixes the stream down to baseband I and Q.
- Integrates over a fixed number of valid samples and dumps one saturated, scaled I/Q pair per window with a single-cycle valid strobe.

---
 rtl/iq_demod_integrate_dump.sv | 141 ++++++++++++++
 tb/tb_iq_demod_integrate_dump.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_demod_integrate_dump.sv
// Coherent I/Q demodulator: mixes the received stream with the NCO carriers,
// integrates over DUMP_LEN valid samples and dumps one scaled, saturated I/Q pair.

module iq_did_chan #(
    parameter int DATA_W = 24,
    parameter int CAR_W  = 24,
    parameter int SHIFT  = 4,
    parameter bit NEG    = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     v1,
    input  logic                     v2,
    input  logic                     first,
    input  logic signed [DATA_W-1:0] y,
    input  logic signed [CAR_W-1:0]  car,
    output logic        [DATA_W-1:0] dump_val,
    output logic                     clip
);
    localparam int PROD_W = DATA_W + CAR_W;
    localparam int ACC_W  = PROD_W + SHIFT;
    localparam int OUT_SH = CAR_W - 1 + SHIFT;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_x, acc, acc_n, sh;
    logic                     hi, lo;

    always_ff @(posedge clk) begin
        if (v1) prod <= NEG ? -(y * car) : (y * car);
    end

    assign prod_x = prod;
    // first sample of a window reloads rather than accumulates
    assign acc_n  = first ? prod_x : acc + prod_x;
    assign sh     = acc_n >>> OUT_SH;
    assign hi     = sh > MAXV;
    assign lo     = sh < MINV;
    assign clip   = hi | lo;

    always_comb begin
        dump_val = sh[DATA_W-1:0];
        if (hi)      dump_val = MAXV[DATA_W-1:0];
        else if (lo) dump_val = MINV[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || clear) acc <= '0;
        else if (v2)        acc <= acc_n;
    end
endmodule

module iq_demod_integrate_dump #(
    parameter int DATA_W   = 24,
    parameter int CAR_W    = 24,
    parameter int DUMP_LEN = 16,
    parameter int SHIFT    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] y_in,
    input  logic [CAR_W-1:0]  cos_in,
    input  logic [CAR_W-1:0]  sin_in,
    input  logic              clear,
    output logic [DATA_W-1:0] i_out,
    output logic [DATA_W-1:0] q_out,
    output logic              out_valid,
    output logic              sat
);
    localparam int STAGES = 1;
    localparam int CNT_W  = $clog2(DUMP_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DUMP_LEN - 1);

    logic [STAGES:0]             vld_pipe;
    logic signed [DATA_W-1:0]    y_r;
    logic [1:0][CAR_W-1:0]       car_r;
    logic [1:0][DATA_W-1:0]      dump_val;
    logic [1:0]                  clip;
    logic [CNT_W-1:0]            cnt;
    logic                        first, last;

    always_ff @(posedge clk) begin
        if (in_valid) begin
            y_r      <= y_in;
            car_r[0] <= cos_in;
            car_r[1] <= sin_in;
        end
    end

    assign first = cnt == '0;
    assign last  = cnt == LAST;

    // channel 0 = I (y*cos), channel 1 = Q (-(y*sin))
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        iq_did_chan #(
            .DATA_W(DATA_W), .CAR_W(CAR_W), .SHIFT(SHIFT), .NEG(ch == 1)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .v1      (vld_pipe[0]),
            .v2      (vld_pipe[1]),
            .first   (first),
            .y       (y_r),
            .car     (car_r[ch]),
            .dump_val(dump_val[ch]),
            .clip    (clip[ch])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            sat       <= 1'b0;
        end else if (clear) begin
            // outputs and sat survive a resync; only in-flight work is dropped
            vld_pipe  <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], in_valid};
            out_valid <= 1'b0;
            if (vld_pipe[1]) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    i_out     <= dump_val[0];
                    q_out     <= dump_val[1];
                    out_valid <= 1'b1;
                    sat       <= sat | (|clip);
                end
            end
        end
    end
endmodule

// File: tb/tb_iq_demod_integrate_dump.sv
// Directed bench for iq_demod_integrate_dump: window timing, sign, saturation,
// bubbles, clear and reset behaviour against hand-computed values.

module tb_iq_demod_integrate_dump;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] y_in = '0, cos_in = '0, sin_in = '0;
    logic [23:0] i_out, q_out;
    logic        out_valid, sat;

    int          passed = 0, total = 0;
    int          cyc = 0, pulse_cnt = 0;
    int          p_cyc [64];
    logic [23:0] p_i   [64];

    iq_demod_integrate_dump #(.DATA_W(24), .CAR_W(24), .DUMP_LEN(16), .SHIFT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .y_in(y_in),
        .cos_in(cos_in), .sin_in(sin_in), .clear(clear),
        .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .sat(sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            if (pulse_cnt < 64) begin
                p_cyc[pulse_cnt] = cyc;
                p_i[pulse_cnt]   = i_out;
            end
            pulse_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n valid samples; with gap, one idle cycle between consecutive samples
    task automatic feed(input logic [23:0] y, c, s, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1; y_in = y; cos_in = c; sin_in = s;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1; y_in = 24'h100000; cos_in = 24'h400000; sin_in = 24'h400000;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({i_out, q_out, out_valid, sat} !== 50'd0)
                $display("FAIL reset_hold cyc%0d: i=%h q=%h v=%b sat=%b, want all 0", i, i_out, q_out, out_valid, sat);
            else passed++;
        end
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
        total++;
        if ({i_out, q_out, out_valid, sat} !== 50'd0)
            $display("FAIL reset_release: i=%h q=%h v=%b sat=%b, want all 0", i_out, q_out, out_valid, sat);
        else passed++;
        tick(); tick(); tick();
        total++;
        if (out_valid !== 1'b0 || pulse_cnt !== 0)
            $display("FAIL reset_no_pulse: v=%b pulses=%0d, want 0/0", out_valid, pulse_cnt);
        else passed++;
    endtask

    task automatic test_dc_i();
        int n0 = pulse_cnt;
        feed(24'h100000, 24'h400000, 24'h000000, 16, 1'b0);
        total++;
        if (out_valid !== 1'b0) $display("FAIL dc_i_early0: v=%b want 0", out_valid); else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL dc_i_early1: v=%b want 0", out_valid); else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || i_out !== 24'h080000 || q_out !== 24'h000000 || sat !== 1'b0)
            $display("FAIL dc_i_dump: v=%b i=%h q=%h sat=%b, want 1 080000 000000 0", out_valid, i_out, q_out, sat);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || i_out !== 24'h080000 || pulse_cnt - n0 !== 1)
            $display("FAIL dc_i_after: v=%b i=%h pulses=%0d, want 0 080000 1", out_valid, i_out, pulse_cnt - n0);
        else passed++;
    endtask

    task automatic test_q_sign();
        int n0 = pulse_cnt;
        feed(24'hF00000, 24'h000000, 24'h400000, 16, 1'b0);
        tick(); tick();
        total++;
        if (out_valid !== 1'b1 || q_out !== 24'h080000 || i_out !== 24'h000000)
            $display("FAIL q_sign: v=%b i=%h q=%h, want 1 000000 080000", out_valid, i_out, q_out);
        else passed++;
        tick();
        total++;
        if (pulse_cnt - n0 !== 1) $display("FAIL q_sign_pulses: got %0d want 1", pulse_cnt - n0); else passed++;
    endtask

    task automatic test_saturation();
        feed(24'h800000, 24'h800000, 24'h000000, 16, 1'b0);
        tick(); tick();
        total++;
        if (out_valid !== 1'b1 || i_out !== 24'h7FFFFF || q_out !== 24'h000000 || sat !== 1'b1)
            $display("FAIL sat_clip: v=%b i=%h q=%h sat=%b, want 1 7fffff 000000 1", out_valid, i_out, q_out, sat);
        else passed++;
        tick();
        feed(24'h100000, 24'h400000, 24'h000000, 16, 1'b0);
        tick(); tick();
        total++;
        if (out_valid !== 1'b1 || i_out !== 24'h080000 || sat !== 1'b1)
            $display("FAIL sat_sticky: v=%b i=%h sat=%b, want 1 080000 1", out_valid, i_out, sat);
        else passed++;
        tick();
        // exactly at the negative rail and one above it: no clipping
        feed(24'h800000, 24'h7FFFFF, 24'h800000, 16, 1'b0);
        tick(); tick();
        total++;
        if (out_valid !== 1'b1 || i_out !== 24'h800001 || q_out !== 24'h800000)
            $display("FAIL sat_neg_edge: v=%b i=%h q=%h, want 1 800001 800000", out_valid, i_out, q_out);
        else passed++;
        tick();
    endtask

    task automatic test_bubbles();
        int n0 = pulse_cnt;
        feed(24'h100000, 24'h400000, 24'h000000, 16, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b0 || pulse_cnt - n0 !== 0)
            $display("FAIL bubble_early: v=%b pulses=%0d, want 0 0", out_valid, pulse_cnt - n0);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || i_out !== 24'h080000)
            $display("FAIL bubble_dump: v=%b i=%h, want 1 080000", out_valid, i_out);
        else passed++;
        tick();
        total++;
        if (pulse_cnt - n0 !== 1) $display("FAIL bubble_pulses: got %0d want 1", pulse_cnt - n0); else passed++;
    endtask

    task automatic test_clear();
        int n0 = pulse_cnt;
        feed(24'h100000, 24'h400000, 24'h000000, 7, 1'b0);
        in_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || i_out !== 24'h080000 || sat !== 1'b1)
            $display("FAIL clear_retain: v=%b i=%h sat=%b, want 0 080000 1", out_valid, i_out, sat);
        else passed++;
        feed(24'h100000, 24'h400000, 24'h000000, 32, 1'b0);
        tick(); tick(); tick();
        total++;
        if (pulse_cnt - n0 !== 2)
            $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - n0);
        else passed++;
        total++;
        if (p_cyc[n0+1] - p_cyc[n0] !== 16 || p_i[n0] !== 24'h080000 || p_i[n0+1] !== 24'h080000)
            $display("FAIL b2b_spacing: gap=%0d i0=%h i1=%h, want 16 080000 080000",
                     p_cyc[n0+1] - p_cyc[n0], p_i[n0], p_i[n0+1]);
        else passed++;

        n0 = pulse_cnt;
        feed(24'h100000, 24'hC00000, 24'h000000, 16, 1'b0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (out_valid !== 1'b0 || i_out !== 24'h080000)
            $display("FAIL clear_on_dump: v=%b i=%h, want 0 080000", out_valid, i_out);
        else passed++;
        tick(); tick();
        total++;
        if (pulse_cnt - n0 !== 0) $display("FAIL clear_on_dump_pulses: got %0d want 0", pulse_cnt - n0); else passed++;
    endtask

    task automatic test_reset_mid();
        int n0;
        feed(24'h100000, 24'h400000, 24'h000000, 5, 1'b0);
        reset = 1'b1;
        tick();
        total++;
        if ({i_out, q_out, out_valid, sat} !== 50'd0)
            $display("FAIL reset_mid: i=%h q=%h v=%b sat=%b, want all 0", i_out, q_out, out_valid, sat);
        else passed++;
        reset = 1'b0;
        n0 = pulse_cnt;
        feed(24'h100000, 24'h400000, 24'h000000, 16, 1'b0);
        tick(); tick();
        total++;
        if (out_valid !== 1'b1 || i_out !== 24'h080000 || sat !== 1'b0)
            $display("FAIL reset_mid_window: v=%b i=%h sat=%b, want 1 080000 0", out_valid, i_out, sat);
        else passed++;
        tick();
        total++;
        if (pulse_cnt - n0 !== 1) $display("FAIL reset_mid_pulses: got %0d want 1", pulse_cnt - n0); else passed++;
    endtask

    initial begin
        test_reset();
        test_dc_i();
        test_q_sign();
        test_saturation();
        test_bubbles();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
